aes_round_engine: RTL and testbench
===================================

// Module: aes_round_engine
// PURPOSE
//  Iterative AES encryption datapath that sits directly downstream of table_lookup and S4.
//  Each cycle it drives its 128-bit state register into four table_lookup instances.
//  It then combines their registered T-table outputs with the round key to form the next state.
//  Final round uses four S4 instances (SubBytes+ShiftRows, no MixColumns); valid/ready on both sides.
// PARAMETERS
//  NR       10   number of rounds; legal values 10/12/14 (AES-128/192/256)
// PORTS
//  clk        in   1    single clock, all flops rising edge
//  rst_n      in   1    asynchronous, active-low reset
//  in_valid   in   1    plaintext valid
//  in_ready   out  1    engine idle, can accept
//  in_data    in   128  plaintext, byte 0 = [127:120], column-major as FIPS-197
//  rk_idx     out  4    round-key index requested this cycle
//  rk         in   128  round key for rk_idx, valid combinationally in the same cycle
//  out_valid  out  1    ciphertext valid, held until accepted
//  out_ready  in   1    consumer accepts
//  out_data   out  128  ciphertext (= state register)
// BEHAVIOUR
//  Reset values: state=0, round=0, FSM=IDLE, in_ready=1, out_valid=0, rk_idx=0.
//  FSM states: IDLE, LOOK, MIX, FLOOK, FMIX, DONE.
//  IDLE:
//   - in_ready=1 and rk_idx=0.
//   - On in_valid: state<=in_data^rk, round<=1, ->LOOK.
//  LOOK:
//   - The lookup tables sample state; they have 1-cycle latency.
//   - rk_idx is don't-care (drive round).
//   - ->MIX.
//  MIX:
//   - rk_idx=round.
//   - state<=z^rk, where words s0..s3 = state[127:96]..[31:0] and pXY = output Y of the lookup on sX:
//     z0=p00^p11^p22^p33; z1=p10^p21^p32^p03; z2=p20^p31^p02^p13; z3=p30^p01^p12^p23.
//   - round<=round+1.
//   - If round==NR-1 ->FLOOK, else ->LOOK.
//  FLOOK: the S4 instances sample state; ->FMIX.
//  FMIX:
//   - rk_idx=NR.
//   - state<=ShiftRows(SubBytes(state))^rk: out col j row r = S(row r, col (j+r) mod 4).
//   - ->DONE.
//  DONE:
//   - out_valid=1, in_ready=0, out_data stable.
//   - On out_ready: ->IDLE, out_valid<=0, round<=0.
//   - No same-cycle re-accept; in_ready rises the cycle after the handshake.
//  Latency: out_valid rises 2*NR cycles after the accepting edge (20 for NR=10).
//  Throughput: one block per 2*NR+2 cycles with out_ready held high.
//  in_ready is high only in IDLE; in_valid in any other state is ignored, and in_data may change freely.
//  in_valid with no accept leaves all state untouched.
//  out_ready outside DONE is ignored.
//  Round counter is 4 bits and never wraps; it is cleared in IDLE.
//  Reset mid-operation:
//   - The block in flight is dropped and all outputs take reset values asynchronously.
//   - The table pipeline flops are not reset and may hold stale data; this is harmless, since LOOK always precedes MIX.
//  rk is sampled only in IDLE-accept, MIX and FMIX; its value in other cycles is irrelevant.
// STRUCTURE
//  aes_pkg.vh (shared include):
//   - NR_128/NR_192/NR_256 and state-word slice macros.
//   - FSM state encodings.
//   - RK_IDX_W=4.
//  Sub-module aes_round_mix (combinational):
//   - 16 lookup words in -> z0..z3 XOR network plus the final-round ShiftRows byte routing.
//   - Shared with a future unrolled core.
//  Top instantiates:
//   - 4x table_lookup and 4x S4, clocked by clk.
//   - The FSM, round counter and state register.
// TESTING
//  1. FIPS-197 App.B, NR=10:
//     key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734
//     -> ct 3925841d02dc09fbdc118597196a0b32, out_valid exactly 20 cycles after accept.
//  2. FIPS-197 App.C.1:
//     key 000102..0f, pt 00112233445566778899aabbccddeeff
//     -> ct 69c4e0d86a7b0430d8cdb78070b4c55a.
//     The rk_idx sequence is 0, then 1..10 in MIX/FMIX cycles.
//  3. Backpressure:
//     - Hold out_ready=0 for 50 cycles after DONE -> out_data/out_valid stable and in_ready=0 throughout.
//     - Release -> in_ready=1 on the next cycle.
//  4. Back-to-back: in_valid and out_ready held high, two App.C.1 blocks -> accepts exactly 22 cycles apart, both ct correct.
//  5. Reset mid-round: assert rst_n=0 in round 5 -> out_valid=0, in_ready=1 immediately; the next block (App.B) encrypts correctly.
//  6. NR=14, FIPS-197 App.C.3:
//     key 000102..1f, pt 00112233..eeff
//     -> ct 8ea2b7ca516745bfeafc49904b496089, latency 28 cycles.

Source files
------------

// File: rtl/aes_round_engine_pkg.sv
// Shared AES definitions for the iterative round engine: round counts, FSM states,
// and GF(2^8) helpers used to build the S-box and T-table lookups.
package aes_round_engine_pkg;

  localparam int unsigned NR_128   = 10;
  localparam int unsigned NR_192   = 12;
  localparam int unsigned NR_256   = 14;
  localparam int unsigned RK_IDX_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOK,
    ST_MIX,
    ST_FLOOK,
    ST_FMIX,
    ST_DONE
  } fsm_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // Inverse as a^254 (square-and-multiply, exponent 8'b1111_1110), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int unsigned i = 0; i < 8; i++) begin
      inv = gf_mul(inv, inv);
      if (i < 7) inv = gf_mul(inv, a);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // T0 column for byte a: {2S, S, S, 3S}; T1..T3 are byte rotations of it.
  function automatic logic [31:0] te0(input logic [7:0] a);
    logic [7:0] s;
    logic [7:0] s2;
    s  = sbox(a);
    s2 = xtime(s);
    return {s2, s, s, s2 ^ s};
  endfunction

endpackage

// File: rtl/S4.sv
// Registered SubBytes of one 32-bit state word (four S-boxes).
module S4
  import aes_round_engine_pkg::*;
(
  input  logic        clk,
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  logic [31:0] word_d;
  logic [31:0] word_q;

  always_comb begin
    word_d = sub_word(word_in);
  end

  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign word_out = word_q;

endmodule

// File: rtl/aes_round_mix.sv
// Combinational round combiner: T-table XOR network for full rounds and
// ShiftRows byte routing of substituted words for the final round.
module aes_round_mix
  import aes_round_engine_pkg::*;
(
  input  logic [31:0]  t_words [4][4],
  input  logic [31:0]  s_words [4],
  output logic [127:0] mix_state,
  output logic [127:0] final_state
);

  always_comb begin
    mix_state   = '0;
    final_state = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      mix_state[127-32*j -: 32] = t_words[j][0] ^ t_words[(j+1)%4][1]
                                ^ t_words[(j+2)%4][2] ^ t_words[(j+3)%4][3];
      for (int unsigned r = 0; r < 4; r++) begin
        final_state[127-32*j-8*r -: 8] = s_words[(j+r)%4][31-8*r -: 8];
      end
    end
  end

endmodule

// File: rtl/table_lookup.sv
// Registered T-table lookup of one state word: output y is T_y applied to byte y.
module table_lookup
  import aes_round_engine_pkg::*;
(
  input  logic        clk,
  input  logic [31:0] word_in,
  output logic [31:0] t_out [4]
);

  logic [31:0] t_d [4];
  logic [31:0] t_q [4];
  logic [31:0] col;

  always_comb begin
    t_d = '{default: '0};
    col = '0;
    for (int unsigned y = 0; y < 4; y++) begin
      col    = te0(word_in[31-8*y -: 8]);
      t_d[y] = (col >> (8*y)) | (col << (32 - 8*y));
    end
  end

  always_ff @(posedge clk) begin
    t_q <= t_d;
  end

  assign t_out = t_q;

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES encryption engine: two cycles per round (lookup, mix) over a
// 128-bit state register, with valid/ready handshakes on input and output.
module aes_round_engine
  import aes_round_engine_pkg::*;
#(
  parameter int unsigned NR = NR_128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  output logic [RK_IDX_W-1:0] rk_idx,
  input  logic [127:0]        rk,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data
);

  localparam logic [RK_IDX_W-1:0] NR_IDX = RK_IDX_W'(NR);

  fsm_e                fsm_q, fsm_d;
  logic [127:0]        state_q, state_d;
  logic [RK_IDX_W-1:0] round_q, round_d;
  logic [RK_IDX_W-1:0] rk_idx_q, rk_idx_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;

  logic [31:0]  t_words [4][4];
  logic [31:0]  s_words [4];
  logic [127:0] mix_state;
  logic [127:0] final_state;

  for (genvar x = 0; x < 4; x++) begin : g_lane
    table_lookup u_tl (
      .clk     (clk),
      .word_in (state_q[127-32*x -: 32]),
      .t_out   (t_words[x])
    );
    S4 u_s4 (
      .clk      (clk),
      .word_in  (state_q[127-32*x -: 32]),
      .word_out (s_words[x])
    );
  end

  aes_round_mix u_mix (
    .t_words     (t_words),
    .s_words     (s_words),
    .mix_state   (mix_state),
    .final_state (final_state)
  );

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    case (fsm_q)
      ST_IDLE: begin
        round_d = '0;
        if (in_valid) begin
          state_d = in_data ^ rk;
          round_d = RK_IDX_W'(1);
          fsm_d   = ST_LOOK;
        end
      end
      ST_LOOK:  fsm_d = ST_MIX;
      ST_MIX: begin
        state_d = mix_state ^ rk;
        round_d = round_q + RK_IDX_W'(1);
        fsm_d   = (round_q == NR_IDX - RK_IDX_W'(1)) ? ST_FLOOK : ST_LOOK;
      end
      ST_FLOOK: fsm_d = ST_FMIX;
      ST_FMIX: begin
        state_d = final_state ^ rk;
        fsm_d   = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          fsm_d   = ST_IDLE;
          round_d = '0;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    case (fsm_d)
      ST_IDLE:         rk_idx_d = '0;
      ST_LOOK, ST_MIX: rk_idx_d = round_d;
      default:         rk_idx_d = NR_IDX;
    endcase
    in_ready_d  = (fsm_d == ST_IDLE);
    out_valid_d = (fsm_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= ST_IDLE;
      state_q     <= '0;
      round_q     <= '0;
      rk_idx_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      round_q     <= round_d;
      rk_idx_q    <= rk_idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign rk_idx    = rk_idx_q;
  assign out_data  = state_q;

endmodule

// File: tb/tb_aes_round_engine.sv
// Self-checking bench for aes_round_engine: FIPS-197 vectors on NR=10 and NR=14 instances,
// with a key-schedule model supplying rk and a scoreboard of expected ciphertexts.
module tb_aes_round_engine;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         sel = 1'b0;
  logic [127:0] in_data = '0;

  logic         iv10, or10, ir10, ov10;
  logic         iv14, or14, ir14, ov14;
  logic [3:0]   ki10, ki14;
  logic [127:0] rk10, rk14, od10, od14;
  logic [127:0] rk_tab10 [16];
  logic [127:0] rk_tab14 [16];

  logic         cur_ir, cur_ov;
  logic [3:0]   cur_ki;
  logic [127:0] cur_od;

  assign iv10   = in_valid & ~sel;
  assign iv14   = in_valid & sel;
  assign or10   = out_ready & ~sel;
  assign or14   = out_ready & sel;
  assign rk10   = rk_tab10[ki10];
  assign rk14   = rk_tab14[ki14];
  assign cur_ir = sel ? ir14 : ir10;
  assign cur_ov = sel ? ov14 : ov10;
  assign cur_ki = sel ? ki14 : ki10;
  assign cur_od = sel ? od14 : od10;

  aes_round_engine #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv10), .in_ready(ir10), .in_data(in_data),
    .rk_idx(ki10), .rk(rk10), .out_valid(ov10), .out_ready(or10), .out_data(od10)
  );

  aes_round_engine #(.NR(14)) dut14 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv14), .in_ready(ir14), .in_data(in_data),
    .rk_idx(ki14), .rk(rk14), .out_valid(ov14), .out_ready(or14), .out_data(od14)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  logic [127:0] exp_q [$];

  typedef struct {
    bit           big;
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;
  vec_t vecs [3];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] tb_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = tb_xt(x);
    end
    return p;
  endfunction

  // Inverse by exhaustive search, affine map written bitwise.
  function automatic logic [7:0] tb_sbox(input logic [7:0] a);
    logic [7:0] inv = '0;
    logic [7:0] c = 8'h63;
    logic [7:0] s;
    for (int b = 1; b < 256; b++) if (tb_mul(a, 8'(b)) == 8'h01) inv = 8'(b);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction

  function automatic logic [31:0] sub_w(input logic [31:0] w);
    return {tb_sbox(w[31:24]), tb_sbox(w[23:16]), tb_sbox(w[15:8]), tb_sbox(w[7:0])};
  endfunction

  task automatic load_keys(input int vi);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int nk, nr;
    sel = vecs[vi].big;
    nk  = sel ? 8 : 4;
    nr  = sel ? 14 : 10;
    for (int i = 0; i < nk; i++) w[i] = vecs[vi].key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = tb_xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_w(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      if (sel) rk_tab14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else     rk_tab10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  // Streams nblk copies of vector vi with out_ready high; checks rk_idx order,
  // latency, ciphertext and (for two blocks) the accept-to-accept spacing.
  task automatic run_stream(input int vi, input int nblk);
    int nr, k;
    int acc [2];
    int n_acc = 0;
    int n_out = 0;
    load_keys(vi);
    nr = vecs[vi].big ? 14 : 10;
    @(negedge clk);
    in_data   = vecs[vi].pt;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 80 * nblk && n_out < nblk; c++) begin
      if (n_acc >= nblk) in_valid = 1'b0;
      if (n_acc == 1 && n_out == 0) begin
        k = cyc - acc[0];
        if (k % 2 == 0 && k >= 2 && k <= 2*nr) check("rk_idx_round", cur_ki, k/2);
      end
      if (in_valid && cur_ir) begin
        check("rk_idx_idle", cur_ki, 0);
        exp_q.push_back(vecs[vi].ct);
        acc[n_acc] = cyc;
        n_acc++;
      end
      if (cur_ov && out_ready) begin
        check("latency", cyc - acc[n_out] - 1, 2*nr);
        check("ciphertext", cur_od, exp_q.pop_front());
        n_out++;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (n_out < nblk) begin
      n_checks++;
      n_fail++;
      $display("FAIL stream_timeout: got %0d outputs expected %0d", n_out, nblk);
    end
    check("in_ready_after_out", cur_ir, 1);
    check("out_valid_after_out", cur_ov, 0);
    if (nblk == 2) check("accept_gap", acc[1] - acc[0], 2*nr + 2);
  endtask

  task automatic backpressure();
    bit got;
    load_keys(0);
    @(negedge clk);
    in_data   = vecs[0].pt;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (cur_ir) begin
        got = 1;
        exp_q.push_back(vecs[0].ct);
      end
      @(negedge clk);
    end
    // Busy-phase noise: offered blocks and early out_ready must both be ignored.
    for (int c = 0; c < 8; c++) begin
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
    end
    check("busy_in_ready", cur_ir, 0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      if (cur_ov) got = 1;
      else @(negedge clk);
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL bp_timeout: got no out_valid expected out_valid=1");
    end
    for (int c = 0; c < 50; c++) begin
      check("bp_hold_data", cur_od, exp_q[0]);
      check("bp_hold_flags", {cur_ov, cur_ir}, 2'b10);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_ready", cur_ir, 1);
    check("bp_release_valid", cur_ov, 0);
    exp_q.delete();
  endtask

  task automatic reset_mid_round();
    load_keys(1);
    @(negedge clk);
    check("mid_pre_ready", cur_ir, 1);
    in_data  = vecs[1].pt;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", cur_ov, 0);
    check("mid_rst_ready", cur_ir, 1);
    check("mid_rst_rk_idx", cur_ki, 0);
    check("mid_rst_data", cur_od, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{1'b0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{1'b0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{1'b1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089};
    for (int i = 0; i < 16; i++) begin
      rk_tab10[i] = '0;
      rk_tab14[i] = '0;
    end

    repeat (3) @(negedge clk);
    check("rst_in_ready", ir10, 1);
    check("rst_out_valid", ov10, 0);
    check("rst_rk_idx", ki10, 0);
    check("rst_out_data", od10, 0);
    check("rst14_flags", {ir14, ov14}, 2'b10);
    rst_n = 1'b1;

    for (int v = 0; v < 2; v++) run_stream(v, 1);
    backpressure();
    run_stream(1, 2);
    reset_mid_round();
    run_stream(0, 1);
    run_stream(2, 1);
    sel = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
